// File: rtl/serial_bus_tx_if.sv
// ---------------------------------------------------------------------------
// serial_bus_tx_if
// Groups the request handshake and the serial bus signals of the initiator-side
// serializer.
//   req_valid/req_ready/req_addr/req_data : parallel write request handshake
//   bus_grant                             : arbiter permission to drive bit slots
//   bus_data_out/bus_data_out_valid       : serial bit and its qualifier
//   bus_mode                              : 1 = data/gap phase, 0 = address/idle
//   busy/done                             : transfer status, completion pulse
// Modports: slave  = the serializer (accepts requests, drives the bus)
//           master = the requester/arbiter side
// ---------------------------------------------------------------------------
interface serial_bus_tx_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  bus_grant;
  logic                  bus_data_out;
  logic                  bus_data_out_valid;
  logic                  bus_mode;
  logic                  busy;
  logic                  done;

  modport slave (
    input  req_valid, req_addr, req_data, bus_grant,
    output req_ready, bus_data_out, bus_data_out_valid, bus_mode, busy, done
  );

  modport master (
    output req_valid, req_addr, req_data, bus_grant,
    input  req_ready, bus_data_out, bus_data_out_valid, bus_mode, busy, done
  );
endinterface

// File: rtl/serial_bus_tx.sv
// ---------------------------------------------------------------------------
// serial_bus_tx
// Initiator-side serializer. Accepts an {address, data} write request, shifts
// the address out LSB-first with bus_mode=0, waits ADDR_GAP idle cycles,
// shifts the data out LSB-first with bus_mode=1, waits END_GAP idle cycles and
// pulses done. Bit slots are only used while bus_grant is high.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   sif   : serial_bus_tx_if.slave (request handshake, bus outputs, status)
// Every output is a register; the combinational process computes the value
// each output takes for the cycle after the coming edge.
// ---------------------------------------------------------------------------
module serial_bus_tx #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_GAP   = 2,
  parameter int END_GAP    = 2
) (
  input logic            clk,
  input logic            rst_n,
  serial_bus_tx_if.slave sif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXV = max2(max2(ADDR_WIDTH, DATA_WIDTH), max2(ADDR_GAP, END_GAP));
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AGAP,
    S_DATA,
    S_EGAP
  } state_t;

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_addr_sr, w_addr_sr;
  logic [DATA_WIDTH-1:0] r_data_sr, w_data_sr;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  r_bit, w_bit;
  logic                  r_vld, w_vld;
  logic                  r_mode, w_mode;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_ready, w_ready;
  logic                  w_accept;

  // r_ready gates acceptance so nothing is taken in the first cycle after
  // reset release, when the state is already IDLE but ready is still low.
  assign w_accept = (r_state == S_IDLE) && r_ready && sif.req_valid;

  always_comb begin
    w_state   = r_state;
    w_addr_sr = r_addr_sr;
    w_data_sr = r_data_sr;
    w_cnt     = r_cnt;
    w_bit     = 1'b0;
    w_vld     = 1'b0;
    w_mode    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_sr = sif.req_addr;
          w_data_sr = sif.req_data;
          w_cnt     = '0;
          w_state   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (sif.bus_grant) begin
          w_bit     = r_addr_sr[0];
          w_vld     = 1'b1;
          w_addr_sr = r_addr_sr >> 1;
          if (r_cnt == CW'(ADDR_WIDTH - 1)) begin
            w_cnt   = '0;
            w_state = S_AGAP;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
      end
      S_AGAP: begin
        // Gap cycles run regardless of grant; the mode flips here, never on a bit.
        w_mode = 1'b1;
        if (r_cnt == CW'(ADDR_GAP - 1)) begin
          w_cnt   = '0;
          w_state = S_DATA;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        w_mode = 1'b1;
        if (sif.bus_grant) begin
          w_bit     = r_data_sr[0];
          w_vld     = 1'b1;
          w_data_sr = r_data_sr >> 1;
          if (r_cnt == CW'(DATA_WIDTH - 1)) begin
            w_cnt   = '0;
            w_state = S_EGAP;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
      end
      S_EGAP: begin
        // END_GAP idle cycles are emitted first; the following edge enters
        // IDLE with done high and bus_mode back at 0.
        if (r_cnt == CW'(END_GAP)) begin
          w_cnt   = '0;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_mode = 1'b1;
          w_cnt  = r_cnt + CW'(1);
        end
      end
      default: begin
        w_cnt   = '0;
        w_state = S_IDLE;
      end
    endcase
    w_busy  = (w_state != S_IDLE);
    w_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr_sr <= '0;
      r_data_sr <= '0;
      r_cnt     <= '0;
      r_bit     <= 1'b0;
      r_vld     <= 1'b0;
      r_mode    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_addr_sr <= w_addr_sr;
      r_data_sr <= w_data_sr;
      r_cnt     <= w_cnt;
      r_bit     <= w_bit;
      r_vld     <= w_vld;
      r_mode    <= w_mode;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_ready   <= w_ready;
    end
  end

  assign sif.req_ready          = r_ready;
  assign sif.bus_data_out       = r_bit;
  assign sif.bus_data_out_valid = r_vld;
  assign sif.bus_mode           = r_mode;
  assign sif.busy               = r_busy;
  assign sif.done               = r_done;

endmodule
